// File: rtl/gnn_result_drain.sv
// gnn_result_drain: captures eight out-of-order layer-2 results, then streams them in slot order with per-node class bits.
module gnn_result_drain #(
  parameter int DW = 21
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [8*DW-1:0] res_data,
  input  logic [7:0]      res_ready,
  output logic            in_ready,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_data,
  output logic [2:0]      m_idx,
  output logic            m_class,
  output logic            m_last,
  output logic [7:0]      cap_mask,
  output logic [3:0]      class_vec,
  output logic            overrun
);
  typedef enum logic {COLLECT, STREAM} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] mem_q [8];
  logic [DW-1:0] mem_d [8];
  logic [7:0]    cap_mask_q, cap_mask_d;
  logic [3:0]    class_vec_q, class_vec_d;
  logic [2:0]    idx_q, idx_d;
  logic          overrun_q, overrun_d;
  logic          fire, last_xfer;
  assign fire      = (state_q == STREAM) && m_ready;
  assign last_xfer = fire && (idx_q == 3'd7);
  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    cap_mask_d  = cap_mask_q;
    class_vec_d = class_vec_q;
    idx_d       = idx_q;
    overrun_d   = overrun_q;
    if (state_q == COLLECT) begin
      for (int k = 0; k < 8; k++)
        if (res_ready[k] && !cap_mask_q[k]) mem_d[k] = res_data[k*DW +: DW];
      cap_mask_d = cap_mask_q | res_ready;
      overrun_d  = overrun_q | (|(res_ready & cap_mask_q));
      if (cap_mask_d == 8'hFF) begin
        state_d = STREAM;
        idx_d   = 3'd0;
        for (int n = 0; n < 4; n++)
          class_vec_d[n] = $signed(mem_d[2*n+1]) > $signed(mem_d[2*n]);
      end
    end else if (last_xfer) begin
      // flags seen on the final accept open the next frame instead of flagging overrun
      state_d    = COLLECT;
      idx_d      = 3'd0;
      cap_mask_d = res_ready;
      for (int k = 0; k < 8; k++)
        if (res_ready[k]) mem_d[k] = res_data[k*DW +: DW];
    end else begin
      overrun_d = overrun_q | (|res_ready);
      idx_d     = fire ? idx_q + 3'd1 : idx_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      cap_mask_q  <= '0;
      class_vec_q <= '0;
      idx_q       <= '0;
      overrun_q   <= 1'b0;
      for (int k = 0; k < 8; k++) mem_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      cap_mask_q  <= cap_mask_d;
      class_vec_q <= class_vec_d;
      idx_q       <= idx_d;
      overrun_q   <= overrun_d;
    end
  end
  assign in_ready  = state_q == COLLECT;
  assign m_valid   = state_q == STREAM;
  assign m_data    = m_valid ? mem_q[idx_q] : '0;
  assign m_idx     = idx_q;
  assign m_class   = m_valid && class_vec_q[idx_q[2:1]];
  assign m_last    = m_valid && (idx_q == 3'd7);
  assign cap_mask  = cap_mask_q;
  assign class_vec = class_vec_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_gnn_result_drain.sv
// tb_gnn_result_drain: table vectors, hand-written corner sequences and random frames against a slot/class model.
module tb_gnn_result_drain;
  localparam int DW = 21;
  typedef logic [8*DW-1:0] frame_t;
  typedef struct {
    frame_t     d;
    logic [3:0] cls;
    int         mode;
    int         bp;
  } vec_t;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  frame_t        res_data = '0;
  logic [7:0]    res_ready = '0;
  logic          in_ready, m_valid, m_class, m_last, overrun;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [2:0]    m_idx;
  logic [7:0]    cap_mask;
  logic [3:0]    class_vec;
  int            total = 0;
  int            bad = 0;
  bit            ov_exp = 0;
  int            ord [8] = '{7, 0, 3, 5, 1, 6, 2, 4};
  vec_t          tv [2];
  frame_t        fa, fb;
  always #5 clk = ~clk;
  gnn_result_drain #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .res_data(res_data), .res_ready(res_ready),
    .in_ready(in_ready), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_idx(m_idx), .m_class(m_class), .m_last(m_last), .cap_mask(cap_mask),
    .class_vec(class_vec), .overrun(overrun)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int sx(input logic [DW-1:0] v);
    int r;
    r = {{(32-DW){v[DW-1]}}, v};
    return r;
  endfunction
  function automatic logic [3:0] model_cls(input frame_t d);
    logic [3:0] c;
    for (int n = 0; n < 4; n++) c[n] = sx(d[(2*n+1)*DW +: DW]) > sx(d[2*n*DW +: DW]);
    return c;
  endfunction
  task automatic chk_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_idx", m_idx, 0);
    chk("rst_m_class", m_class, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_cap_mask", cap_mask, 0);
    chk("rst_class_vec", class_vec, 0);
    chk("rst_overrun", overrun, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ov_exp = 0;
    chk_reset();
  endtask
  // mode 0: all missing flags at once, 1: one slot per cycle in ord, 2: random subsets
  task automatic fill(input frame_t d, input int mode, input logic [7:0] start, input int o [8]);
    logic [7:0] m = start;
    logic [7:0] s;
    int cyc = 0;
    res_data = d;
    chk("fill_in_ready", in_ready, 1);
    while (m != 8'hFF && cyc < 64) begin
      s = mode == 0 ? ~m : mode == 1 ? (8'h01 << o[cyc%8]) : (8'($urandom) & ~m);
      res_ready = s;
      step();
      res_ready = '0;
      m |= s;
      cyc++;
      chk("fill_cap_mask", cap_mask, m);
      chk("fill_m_valid", m_valid, m == 8'hFF);
    end
    if (m != 8'hFF) chk("fill_timeout", 0, 1);
    chk("fill_in_ready_low", in_ready, 0);
    chk("fill_class_vec", class_vec, model_cls(d));
  endtask
  // bp 0: always ready, 1: 1,0,0 repeating, 2: random
  task automatic drain(input frame_t d, input int bp, input logic [7:0] lmask, input frame_t ld);
    logic [3:0] c = model_cls(d);
    int cnt = 0;
    int cyc = 0;
    while (cnt < 8 && cyc < 100) begin
      chk("m_valid", m_valid, 1);
      chk("m_idx", m_idx, cnt);
      chk("m_data", m_data, d[cnt*DW +: DW]);
      chk("m_class", m_class, c[cnt/2]);
      chk("m_last", m_last, cnt == 7);
      chk("class_vec", class_vec, c);
      m_ready = bp == 0 ? 1'b1 : bp == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      if (m_ready && cnt == 7 && lmask != 0) begin
        res_data = ld;
        res_ready = lmask;
      end
      step();
      res_ready = '0;
      if (m_ready) cnt++;
      cyc++;
    end
    m_ready = 1'b0;
    chk("drain_count", cnt, 8);
    chk("post_m_valid", m_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_cap_mask", cap_mask, lmask);
    chk("post_overrun", overrun, ov_exp);
  endtask
  function automatic frame_t rand_frame();
    frame_t d;
    for (int k = 0; k < 8; k++) d[k*DW +: DW] = DW'($urandom);
    for (int n = 0; n < 4; n++)
      if ($urandom_range(0, 3) == 0) d[(2*n+1)*DW +: DW] = d[2*n*DW +: DW];
    return d;
  endfunction
  initial begin
    tv[0] = '{d: {21'd8, 21'd7, 21'd5, 21'h1FFFFF, 21'd4, 21'd3, 21'd2, 21'd1}, cls: 4'b1111, mode: 0, bp: 0};
    tv[1] = '{d: {21'h100000, 21'd0, 21'd2, 21'd7, 21'h1FFFFD, 21'h1FFFFB, 21'd100, 21'd100}, cls: 4'b0010, mode: 1, bp: 1};
    step();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      fill(tv[i].d, tv[i].mode, 8'h00, ord);
      chk("table_cls", class_vec, tv[i].cls);
      drain(tv[i].d, tv[i].bp, 8'h00, '0);
    end
    // re-flagged slot keeps its first value
    fa = rand_frame();
    res_data = fa;
    res_ready = 8'h04;
    step();
    fb = fa;
    fb[2*DW +: DW] = ~fa[2*DW +: DW];
    res_data = fb;
    step();
    res_ready = '0;
    ov_exp = 1;
    chk("ovr_set", overrun, 1);
    chk("ovr_mask", cap_mask, 8'h04);
    fill(fa, 2, 8'h04, ord);
    drain(fa, 2, 8'h00, '0);
    do_reset();
    // flag during stream is not captured
    fa = rand_frame();
    fill(fa, 0, 8'h00, ord);
    res_ready = 8'h01;
    step();
    res_ready = '0;
    ov_exp = 1;
    chk("stream_ovr", overrun, 1);
    chk("stream_mask", cap_mask, 8'hFF);
    chk("stream_idx_hold", m_idx, 0);
    drain(fa, 0, 8'h00, '0);
    do_reset();
    // flag on the last accept opens the next frame
    fa = rand_frame();
    fb = rand_frame();
    fill(fa, 2, 8'h00, ord);
    drain(fa, 0, 8'h04, fb);
    fill(fb, 2, 8'h04, ord);
    drain(fb, 2, 8'h00, '0);
    // reset mid-stream
    fa = rand_frame();
    fill(fa, 0, 8'h00, ord);
    m_ready = 1'b1;
    for (int c = 0; c < 10 && m_idx != 3'd3; c++) step();
    chk("mid_idx", m_idx, 3);
    m_ready = 1'b0;
    do_reset();
    step();
    chk("mid_post_in_ready", in_ready, 1);
    chk("mid_post_m_valid", m_valid, 0);
    for (int r = 0; r < 20; r++) begin
      fa = rand_frame();
      fill(fa, r % 3 == 0 ? 0 : 2, 8'h00, ord);
      drain(fa, 2, 8'h00, '0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gnn_result_drain.md
# gnn_result_drain

Result-collection back end for the GNN accelerator's `top`. It captures the eight 21-bit layer-2 results as their per-output ready flags fire; the flags may arrive in any order and on different cycles. Once all eight are held, it computes a per-node class bit and streams the words out in fixed order over a valid/ready interface. It sits between `top` and the host-side readout logic, and it owns `in_ready` toward the accelerator.

## Interface
Parameters:
- `DW`, default 21: result word width; must match `top` output width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous and active-high.
- `res_data`  in  8*DW  packed results; slot k = 2*node + out, at bits [k*DW +: DW] (slot 0 = out0_node0, slot 7 = out1_node3).
- `res_ready`  in  8  per-slot ready flags (slot k = out{k%2}{...}_ready_node{k/2}); level or pulse.
- `in_ready`  out  1  start/enable to `top`; high while the block can accept a new frame.
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DW  stream word, two's complement.
- `m_idx`  out  3  slot index of `m_data`.
- `m_class`  out  1  class bit of node `m_idx[2:1]`.
- `m_last`  out  1  high on the slot-7 word.
- `cap_mask`  out  8  slots captured in the current frame.
- `class_vec`  out  4  per-node class bits of the frame being streamed.
- `overrun`  out  1  sticky error; cleared only by `rst`.

## Operation
- FSM has two states.
  - COLLECT (reset state): `in_ready`=1, `m_valid`=0.
  - STREAM: `in_ready`=0, `m_valid`=1.
- Capture rule, COLLECT only:
  - For each k with `res_ready[k]`=1 and `cap_mask[k]`=0, register `res_data` slot k and set `cap_mask[k]`. Multiple slots may capture in one cycle.
  - If `res_ready[k]`=1 while `cap_mask[k]`=1, keep the stored word and set `overrun`.
- COLLECT→STREAM: when the next-state mask equals 8'hFF.
  - On the same edge, `m_idx`←0 and `class_vec[n]`←(signed out1_n > signed out0_n). A tie gives 0.
- STREAM:
  - A transfer occurs when `m_valid`&`m_ready`.
  - Each transfer increments `m_idx`.
  - `m_data` = stored slot `m_idx`; `m_class` = `class_vec[m_idx>>1]`; `m_last` = (`m_idx`==7).
  - Any `res_ready` bit high during STREAM sets `overrun` and captures nothing, except on the last-transfer cycle.
- Last transfer (idx 7 accepted): next state COLLECT. `cap_mask` ← `res_ready` (new frame begins with flags present that cycle). `overrun` is not set in this cycle.
- Arithmetic: the comparison is a DW-bit signed comparison. No other arithmetic besides the 3-bit index increment, which never wraps because the exit is at 7.

## Timing
- Reset values: state COLLECT, `in_ready`=1, `m_valid`=0, `m_data`=0, `m_idx`=0, `m_class`=0, `m_last`=0, `cap_mask`=0, `class_vec`=0, `overrun`=0, and all stored words 0.
- Capture latency: a flag sampled at edge t is visible in `cap_mask` after edge t.
- Collect-to-stream latency: last missing flag sampled at edge t → `m_valid`=1 after edge t (one cycle).
- `in_ready` falls on the same edge that `m_valid` rises.
- Stall behaviour: while `m_valid`=1 and `m_ready`=0, `m_data`, `m_idx`, `m_class` and `m_last` hold stable.
- Throughput: 8 cycles to drain a frame with `m_ready` held high.
- The cycle after the idx-7 transfer: `m_valid`=0, `in_ready`=1.
- Reset mid-frame or mid-stream: the frame is abandoned and all outputs return to their reset values after the reset edge. No partial stream resumes.

## Test plan
- **In-order collection:** raise all 8 flags together for one cycle. Slot data = 1..8, except out0_node2=21'h1FFFFF (−1) and out1_node2=5. Required response:
  - `cap_mask`=FF, then `m_valid` is high the next cycle.
  - With `m_ready`=1, words stream as idx 0..7.
  - `class_vec`=4'b1111 with slot values 1..8 (node2: 5>−1).
  - `m_last` is high only at idx 7.
- **Scattered arrival:** pulse slots in order 7,0,3,5,1,6,2,4, one per cycle. Required response:
  - `cap_mask` accumulates bit by bit.
  - `m_valid` rises the cycle after the slot-4 pulse.
  - Output order is still 0..7.
- **Backpressure:** toggle `m_ready` 1,0,0,1,... during the stream. Required response: outputs are stable across every stall, there are exactly 8 transfers, and no word is duplicated or skipped.
- **Ties and sign:** node0 out0=out1=100 → class 0. Node1 out0=−5, out1=−3 → class 1. Node3 out0=0, out1=21'h100000 (most negative) → class 0.
- **Overrun:** re-pulse slot 2 with a new value before the frame completes. Required response: `overrun`=1, and the originally captured value is streamed. A flag during STREAM also sets `overrun`. A flag on the idx-7 accept cycle does not set `overrun`; it is captured instead, and `cap_mask` shows that bit afterwards.
- **Reset mid-stream:** assert `rst` at idx 3. Required response: the next cycle shows all outputs at their reset values, `in_ready`=1, and `overrun`=0.
